md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the Execute stage of the pipelined MIPS CPU. It executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers. It provides mfhi/mflo data to the E-stage result mux, which feeds the E-to-M pipeline register. It models fixed multi-cycle latency with a busy counter, and the hazard unit uses its stall request to freeze D-stage md-class instructions.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥1).
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: E-stage instruction is md-class and E is not flushed.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- hilo_sel  input  1  read select: 0 LO, 1 HI.
- hilo_out  output  32  combinational read of the selected register.
- busy  output  1  operation in progress.
- stall_req  output  1  start | busy.
- HI, LO  output  32 each  architectural registers.

## Operation
- State: IDLE, RUN. Internal: counter cnt (4+ bits, wide enough for max(MULT_CYCLES, DIV_CYCLES)), pending hi_p/lo_p.
- IDLE, start with md_op 1–4: compute result from A/B this cycle and latch it into hi_p/lo_p. Load cnt with MULT_CYCLES or DIV_CYCLES, then go to RUN.
- IDLE, start with md_op 5: HI←A at this edge. With md_op 6: LO←A. Stays IDLE, busy never rises.
- IDLE, start with md_op 0 or 7: no effect.
- RUN: cnt decrements each edge. On the edge where cnt==1: HI←hi_p, LO←lo_p, go to IDLE.
- start while busy: ignored entirely, including mthi/mtlo. The hazard unit guarantees this does not occur; it is not an error.
- mult: signed 32×32 into a 64-bit result, HI=[63:32], LO=[31:0]. multu: unsigned.
- div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
- Divide by zero (B==0): the counter still runs its full DIV_CYCLES. HI/LO are left unchanged at commit.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- hilo_out = hilo_sel ? HI : LO, reflecting the current registers. mfhi/mflo is stalled while stall_req is high, so it never reads a stale value.
- Reset has priority over everything, including mid-operation: HI=LO=0, busy=0, cnt=0, hi_p=lo_p=0, state IDLE. Any pending result is discarded.

## Timing
- Reset values: HI=0, LO=0, busy=0, stall_req=0 (absent start), hilo_out=0.
- Start sampled at edge T0. busy=1 for cycles T0+1 … T0+N (N=MULT_CYCLES or DIV_CYCLES). HI/LO update at edge T0+N and are visible from cycle T0+N+1, the same cycle busy reads 0.
- stall_req is high combinationally in the start cycle and in all busy cycles. This makes N+1 consecutive stall cycles for a mult followed by mfhi.
- mthi/mtlo: single edge, visible next cycle, stall_req high only in the start cycle.
- Back-to-back: start may be accepted in the cycle immediately after busy falls.
- The unit does not depend on E-to-M register enable. start is qualified upstream.

## Test plan
- Reset mid-run: mult A=3, B=4, then reset at busy cycle 2. Required: HI=LO=0 and busy=0 the next cycle, and no later commit.
- mult A=0xFFFFFFFF, B=2. Required: busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. The same operands via multu give HI=1, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2. Required: 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 gives LO=3, HI=1.
- Preload via mthi 0x1234, mtlo 0x5678 (each visible next cycle, busy stays 0), then div by B=0. Required: after 10 cycles HI=0x1234, LO=0x5678. Then 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- start with mthi A=0xAA while busy. Required: ignored, and the final HI equals the mult result.
- hilo_sel toggling after commit. Required: hilo_out alternates HI/LO. stall_req equals start|busy on every cycle.

Source files
------------

// File: rtl/md_if.sv
// md_if: bundle between the E stage and the multiply/divide unit.
//   master (E stage): drives start, md_op, A, B, hilo_sel; reads the rest.
//   slave  (md_unit): drives hilo_out, busy, stall_req, HI, LO.
//   start     one-cycle pulse for a qualified md-class instruction
//   md_op     0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 no-op
//   A, B      forwarded rs / rt operands
//   hilo_sel  read select for hilo_out (0 LO, 1 HI)
//   hilo_out  combinational read of the selected register
//   busy      multi-cycle operation in progress
//   stall_req start | busy, consumed by the hazard unit
//   HI, LO    architectural registers
interface md_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hilo_sel;
    logic [31:0] hilo_out;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B, hilo_sel,
        input  hilo_out, busy, stall_req, HI, LO
    );

    modport slave (
        input  start, md_op, A, B, hilo_sel,
        output hilo_out, busy, stall_req, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit holding the architectural HI/LO.
//   clk    clock, all state changes on posedge
//   reset  synchronous active-high reset, highest priority
//   md     md_if.slave bundle (operation request, HI/LO read, busy/stall)
// mult/multu/div/divu compute their result in the start cycle, park it in
// hi_p/lo_p and commit it after a fixed busy period. mthi/mtlo write in one
// edge. Requests arriving while busy are ignored.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [31:0]        hi_q, hi_n, lo_q, lo_n;
    logic [31:0]        hi_p, hi_p_n, lo_p, lo_p_n;
    logic               keep_p, keep_p_n;   // divide by zero: leave HI/LO alone

    // ---------------- datapath (evaluated every cycle, used on start) ----
    logic [63:0] prod_s, prod_u;
    logic [31:0] divisor, abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u;

    always_comb begin
        // Low 64 bits of the product of sign-extended operands are the
        // exact two's-complement signed product.
        prod_s  = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
        prod_u  = {32'b0, md.A} * {32'b0, md.B};

        // Divisor forced non-zero so the quotient stays defined; the result
        // is discarded for B==0 anyway.
        divisor = (md.B == 32'd0) ? 32'd1 : md.B;
        q_u     = md.A / divisor;
        r_u     = md.A % divisor;

        // Signed divide on magnitudes: 0x80000000 has magnitude 2^31, which
        // fits unsigned, so 0x80000000 / -1 wraps to 0x80000000 without trap.
        abs_a   = md.A[31] ? (~md.A + 32'd1) : md.A;
        abs_b   = divisor[31] ? (~divisor + 32'd1) : divisor;
        q_mag   = abs_a / abs_b;
        r_mag   = abs_a % abs_b;
        q_s     = (md.A[31] ^ divisor[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s     = md.A[31] ? (~r_mag + 32'd1) : r_mag;
    end

    // ---------------- next-state / register updates ----------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_n  = state;
        cnt_n    = cnt;
        hi_n     = hi_q;
        lo_n     = lo_q;
        hi_p_n   = hi_p;
        lo_p_n   = lo_p;
        keep_p_n = keep_p;

        unique case (state)
            IDLE: begin
                if (md.start) begin
                    unique case (md.md_op)
                        OP_MULT: begin
                            hi_p_n   = prod_s[63:32];
                            lo_p_n   = prod_s[31:0];
                            keep_p_n = 1'b0;
                            cnt_n    = CNT_W'(MULT_CYCLES);
                            state_n  = RUN;
                        end
                        OP_MULTU: begin
                            hi_p_n   = prod_u[63:32];
                            lo_p_n   = prod_u[31:0];
                            keep_p_n = 1'b0;
                            cnt_n    = CNT_W'(MULT_CYCLES);
                            state_n  = RUN;
                        end
                        OP_DIV: begin
                            hi_p_n   = r_s;
                            lo_p_n   = q_s;
                            keep_p_n = (md.B == 32'd0);
                            cnt_n    = CNT_W'(DIV_CYCLES);
                            state_n  = RUN;
                        end
                        OP_DIVU: begin
                            hi_p_n   = r_u;
                            lo_p_n   = q_u;
                            keep_p_n = (md.B == 32'd0);
                            cnt_n    = CNT_W'(DIV_CYCLES);
                            state_n  = RUN;
                        end
                        OP_MTHI: hi_n = md.A;
                        OP_MTLO: lo_n = md.A;
                        default: ;   // none / reserved
                    endcase
                end
            end
            RUN: begin
                // Any start seen here is ignored, mthi/mtlo included.
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    if (!keep_p) begin
                        hi_n = hi_p;
                        lo_n = lo_p;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the pending result registers are reset too, so an
            // operation cut off by reset can never leak into HI/LO later.
            state  <= IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            hi_p   <= '0;
            lo_p   <= '0;
            keep_p <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            hi_q   <= hi_n;
            lo_q   <= lo_n;
            hi_p   <= hi_p_n;
            lo_p   <= lo_p_n;
            keep_p <= keep_p_n;
        end
    end

    // ---------------- outputs ---------------------------------------------
    assign md.busy      = (state == RUN);
    assign md.stall_req = md.start | md.busy;
    assign md.HI        = hi_q;
    assign md.LO        = lo_q;
    assign md.hilo_out  = md.hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: cycle-by-cycle comparison of md_unit against an arithmetic
// reference model (64-bit integer math, countdown of remaining busy cycles),
// with directed cases followed by randomized traffic.
module tb_md_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_if bus ();

    md_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .md   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_ph, m_pl;
    logic        m_commit;
    int          m_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, compare outputs, then advance model and clock.
    task automatic cycle(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sel, input logic rst);
        logic        m_busy;
        longint      sa, sb, sp;
        longint unsigned up;
        reset        = rst;
        bus.start    = st;
        bus.md_op    = op;
        bus.A        = a;
        bus.B        = b;
        bus.hilo_sel = sel;
        #1;
        m_busy = (m_left > 0);
        check("busy",      32'(bus.busy),      32'(m_busy));
        check("stall_req", 32'(bus.stall_req), 32'(st | m_busy));
        check("hilo_out",  bus.hilo_out,       sel ? m_hi : m_lo);
        check("HI",        bus.HI,             m_hi);
        check("LO",        bus.LO,             m_lo);

        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_commit = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_commit) begin
                m_hi = m_ph;
                m_lo = m_pl;
            end
        end else if (st) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                3'd1: begin
                    sp = sa * sb;
                    m_ph = sp[63:32]; m_pl = sp[31:0]; m_commit = 1; m_left = MULT_N;
                end
                3'd2: begin
                    up = longint'(a) * longint'(b);
                    m_ph = up[63:32]; m_pl = up[31:0]; m_commit = 1; m_left = MULT_N;
                end
                3'd3: begin
                    m_commit = (b != 0);
                    if (b != 0) begin
                        sp = sa / sb; m_pl = sp[31:0];
                        sp = sa % sb; m_ph = sp[31:0];
                    end
                    m_left = DIV_N;
                end
                3'd4: begin
                    m_commit = (b != 0);
                    if (b != 0) begin
                        m_pl = a / b;
                        m_ph = a % b;
                    end
                    m_left = DIV_N;
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic sel);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 32'd0, 32'd0, sel, 1'b0);
    endtask

    // Issue one operation and run until busy drops; return busy cycle count.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy);
        int guard;
        cycle(1'b1, op, a, b, 1'b0, 1'b0);
        nbusy = 0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 40) begin
            nbusy++;
            guard++;
            cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        end
        if (guard >= 40) check("busy_timeout", 32'(guard), 32'd0);
    endtask

    initial begin
        int nb;
        logic        st, sel, rst;
        logic [2:0]  op;
        logic [31:0] a, b;

        // Initial reset (outputs are unknown before it, so nothing is compared)
        reset = 1'b1;
        bus.start = 1'b0; bus.md_op = 3'd0; bus.A = '0; bus.B = '0; bus.hilo_sel = 1'b0;
        m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_left = 0; m_commit = 0;
        repeat (2) @(posedge clk);
        #1;
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Reset in the second busy cycle of a mult discards the result
        cycle(1'b1, 3'd1, 32'd3, 32'd4, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        idle(8, 1'b0);
        check("rst_mid_lo", bus.LO, 32'd0);

        // mult / multu
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, nb);
        check("mult_cycles", 32'(nb), 32'd5);
        check("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, nb);
        check("multu_hi", bus.HI, 32'd1);
        check("multu_lo", bus.LO, 32'hFFFF_FFFE);

        // div / divu (back-to-back with the previous op)
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, nb);
        check("div_cycles", 32'(nb), 32'd10);
        check("div_lo", bus.LO, 32'hFFFF_FFFD);
        check("div_hi", bus.HI, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd7, 32'd2, nb);
        check("divu_lo", bus.LO, 32'd3);
        check("divu_hi", bus.HI, 32'd1);

        // mthi / mtlo preload, then divide by zero keeps them
        cycle(1'b1, 3'd5, 32'h1234, 32'd0, 1'b1, 1'b0);
        check("mthi_val", bus.HI, 32'h1234);
        cycle(1'b1, 3'd6, 32'h5678, 32'd0, 1'b0, 1'b0);
        check("mtlo_val", bus.LO, 32'h5678);
        check("mt_busy", 32'(bus.busy), 32'd0);
        run_op(3'd3, 32'd5, 32'd0, nb);
        check("div0_cycles", 32'(nb), 32'd10);
        check("div0_hi", bus.HI, 32'h1234);
        check("div0_lo", bus.LO, 32'h5678);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        check("divovf_lo", bus.LO, 32'h8000_0000);
        check("divovf_hi", bus.HI, 32'd0);

        // mthi / mtlo while busy are ignored
        cycle(1'b1, 3'd1, 32'hFFFF_FFFA, 32'd7, 1'b0, 1'b0);
        cycle(1'b1, 3'd5, 32'hAA, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 3'd6, 32'hBB, 32'd0, 1'b0, 1'b0);
        idle(4, 1'b1);
        check("ign_hi", bus.HI, 32'hFFFF_FFFF);
        check("ign_lo", bus.LO, 32'hFFFF_FFD6);

        // hilo_sel toggling
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 32'd0, 32'd0, i[0], 1'b0);

        // Randomized traffic, including starts while busy and rare resets
        for (int i = 0; i < 1500; i++) begin
            st  = ($urandom_range(0, 2) == 0);
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 7) == 0) ? 32'd0 :
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
            sel = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0);
            cycle(st, op, a, b, sel, rst);
        end
        idle(12, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
